// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit and its requester arbiter.
//   - OP_* : opcode encodings understood by logic_unit (5..7 are illegal)
//   - arb_state_e : arbiter FSM state encoding
package logic_unit_pkg;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational WIDTH-bit bitwise logic unit.
// Ports:
//   op  : opcode (see logic_unit_pkg OP_*)
//   a,b : operands (b ignored for NOT)
//   y   : result, zero for an illegal opcode
//   err : high for an illegal opcode (5..7)
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_NAND: y = ~(a & b);
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between NREQ requesters.
// One operation at a time: IDLE (grant) -> EXEC (evaluate) -> RESP (hold until consumed).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake; req_ready is a one-hot accept pulse
//   req_op/req_a/req_b    : packed per-requester opcode and operands
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id/rsp_data/rsp_err : registered response, tagged with requester index
// Optional: define LOGIC_ARB_STATS_EN to add ops_done, a saturating count of
// completed response handshakes.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [15:0]           ops_done
`endif
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   sel_q, sel_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [2:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  logic [IDW-1:0]   grant_idx, cand;
  logic             grant_found;
  logic [WIDTH-1:0] lu_y;
  logic             lu_err;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      op_arr[i] = req_op[3*i +: 3];
      a_arr[i]  = req_a[WIDTH*i +: WIDTH];
      b_arr[i]  = req_b[WIDTH*i +: WIDTH];
    end
  end

  // First valid requester at or above rr_ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = rr_ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // Gated by rst_n so no accept pulse is seen while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (lu_y),
    .err (lu_err)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          sel_d   = grant_idx;
          op_d    = op_arr[grant_idx];
          a_d     = a_arr[grant_idx];
          b_d     = b_arr[grant_idx];
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = lu_y;
        rsp_err_d   = lu_err;
        rsp_id_d    = sel_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Just-served requester drops to lowest priority.
          rr_ptr_d    = (sel_q == IDW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] ops_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done_q <= '0;
    end else if (rsp_valid_q && rsp_ready && ops_done_q != 16'hFFFF) begin
      ops_done_q <= ops_done_q + 16'd1;
    end
  end

  assign ops_done = ops_done_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0]           ops_done;
`endif

  logic_unit_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .ops_done  (ops_done)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int id, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b);
    req_valid[id]              = 1'b1;
    req_op[3*id +: 3]          = op;
    req_a[WIDTH*id +: WIDTH]   = a;
    req_b[WIDTH*id +: WIDTH]   = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int          grants[6];
    int          ng;
    int          gid;
    logic        bad;
    logic [15:0] hold_data;

    vecs[0]  = '{0, 3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[1]  = '{1, 3'd0, 16'hAAAA, 16'hCCCC, 16'h7777, 1'b0};
    vecs[2]  = '{1, 3'd1, 16'hAAAA, 16'hCCCC, 16'h5555, 1'b0};
    vecs[3]  = '{1, 3'd2, 16'hAAAA, 16'hCCCC, 16'h8888, 1'b0};
    vecs[4]  = '{1, 3'd3, 16'hAAAA, 16'hCCCC, 16'hEEEE, 1'b0};
    vecs[5]  = '{1, 3'd4, 16'hAAAA, 16'hCCCC, 16'h6666, 1'b0};
    vecs[6]  = '{3, 3'd6, 16'h1234, 16'h5678, 16'h0000, 1'b1};
    vecs[7]  = '{2, 3'd5, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};
    vecs[8]  = '{2, 3'd7, 16'h0F0F, 16'h00FF, 16'h0000, 1'b1};
    vecs[9]  = '{0, 3'd4, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0};
    vecs[10] = '{2, 3'd1, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};

    // Reset state, with all requesters asserting valid during reset.
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_valid = '1;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
`ifdef LOGIC_ARB_STATS_EN
    check("rst_ops_done", 32'(ops_done), 32'h0);
`endif
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // Table-driven single operations; only one requester valid at a time.
    for (int v = 0; v < 11; v++) begin
      post(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b);
      #1;
      check($sformatf("v%0d_ready", v), 32'(req_ready), 32'(1) << vecs[v].id);
      tick();
      // Accepted; scramble operands to prove they were latched.
      req_valid = '0;
      req_a     = ~req_a;
      req_b     = ~req_b;
      req_op[3*vecs[v].id +: 3] = 3'd3;
      #1;
      check($sformatf("v%0d_exec_ready", v), 32'(req_ready), 32'h0);
      check($sformatf("v%0d_exec_valid", v), 32'(rsp_valid), 32'h0);
      tick();
      check($sformatf("v%0d_valid", v), 32'(rsp_valid), 32'h1);
      check($sformatf("v%0d_id", v), 32'(rsp_id), 32'(vecs[v].id));
      check($sformatf("v%0d_data", v), 32'(rsp_data), 32'(vecs[v].y));
      check($sformatf("v%0d_err", v), 32'(rsp_err), 32'(vecs[v].err));
      rsp_ready = 1'b1;
      tick();
      check($sformatf("v%0d_drop", v), 32'(rsp_valid), 32'h0);
      rsp_ready = 1'b0;
    end
`ifdef LOGIC_ARB_STATS_EN
    check("ops_done_11", 32'(ops_done), 32'd11);
`endif

    // Round-robin: all valid, consumer always ready.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      post(i, 3'd2, 16'(16'h1111 * (i + 1)), 16'hFFFF);
    end
    rsp_ready = 1'b1;
    ng = 0;
    #1;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      if (rsp_valid) begin
        check("rr_rsp_data", 32'(rsp_data), 32'(16'h1111 * (32'(rsp_id) + 1)));
      end
      if (req_ready != '0) begin
        gid = -1;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) gid = k;
        grants[ng] = gid;
        ng++;
      end
      if (ng < 6) tick();
    end
    check("rr_count", 32'(ng), 32'd6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(k % NREQ));
    end

    // Backpressure: requester 2 served and held, requester 3 waiting.
    do_reset();
    post(2, 3'd3, 16'h1200, 16'h0034);
    post(3, 3'd4, 16'hFFFF, 16'h00FF);
    #1;
    check("bp_ready2", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    tick();
    check("bp_valid", 32'(rsp_valid), 32'h1);
    check("bp_id", 32'(rsp_id), 32'd2);
    check("bp_data", 32'(rsp_data), 32'h1234);
    hold_data = rsp_data;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== hold_data ||
          rsp_err !== 1'b0 || req_ready !== '0) bad = 1'b1;
    end
    check("bp_stable", 32'(bad), 32'h0);
    rsp_ready = 1'b1;
    tick();
    check("bp_drop", 32'(rsp_valid), 32'h0);
    check("bp_next_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    tick();
    check("bp_id3", 32'(rsp_id), 32'd3);
    check("bp_data3", 32'(rsp_data), 32'hFF00);
    tick();
    rsp_ready = 1'b0;

    // Reset mid-operation with rr_ptr non-zero.
    do_reset();
    rsp_ready = 1'b1;
    post(2, 3'd2, 16'hFFFF, 16'h0F0F);
    tick();
    req_valid = '0;
    tick();
    check("mr_pre_data", 32'(rsp_data), 32'h0F0F);
    tick();
    post(3, 3'd3, 16'h00F0, 16'h000F);
    #1;
    check("mr_ready3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mr_rsp_data", 32'(rsp_data), 32'h0);
    check("mr_rsp_id", 32'(rsp_id), 32'h0);
    check("mr_rsp_err", 32'(rsp_err), 32'h0);
    req_valid = 4'b1100;
    #1;
    check("mr_ready_in_rst", 32'(req_ready), 32'h0);
`ifdef LOGIC_ARB_STATS_EN
    check("mr_ops_done", 32'(ops_done), 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    #1;
    check("mr_first_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    tick();
    check("mr_rsp_id2", 32'(rsp_id), 32'd2);
    check("mr_rsp_data2", 32'(rsp_data), 32'h0F0F);
    tick();
    rsp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one bitwise logic unit (NAND/NOT/AND/OR/XOR over WIDTH bits) between NREQ requesters.
- Each requester posts an opcode and operands through a valid/ready handshake.
- Round-robin grant; the chosen operation is executed and the registered result is returned on a single response channel, tagged with the requester id.
- Sits between per-channel command sources and the shared gate datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/result width in bits.
- IDW, 2, requester id width; must equal ceil(log2(NREQ)), minimum 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  bit i = requester i has a command.
- req_ready  output  NREQ  one-hot accept pulse, combinational from state and pointer.
- req_op  input  3*NREQ  opcode of requester i at [3i+2:3i].
- req_a  input  WIDTH*NREQ  operand A of requester i.
- req_b  input  WIDTH*NREQ  operand B of requester i (ignored for NOT).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  IDW  requester index of the response.
- rsp_data  output  WIDTH  registered result.
- rsp_err  output  1  illegal opcode flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, req_ready=0.
- Opcodes:
  - 0 NAND = ~(a&b)
  - 1 NOT = ~a
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5..7 illegal: rsp_data=0, rsp_err=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, select the first set bit searching from rr_ptr upward with wrap at NREQ-1→0.
  - Assert req_ready[sel] combinationally in the same cycle.
  - At the clock edge, latch op/a/b/sel and go to EXEC.
  - No valid: stay in IDLE, req_ready=0.
- EXEC: the logic unit evaluates the latched operands. At the edge, register rsp_data, rsp_err and rsp_id=sel, set rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_valid and all rsp_* stable until rsp_ready=1 at an edge.
  - On that edge, clear rsp_valid, set rr_ptr = (sel+1) mod NREQ, go to IDLE.
  - req_ready stays 0 throughout.
- Latency: handshake at edge T, rsp_valid high after edge T+1. Minimum 3 cycles per operation; no overlap.
- Fairness: the just-served requester has lowest priority on the next grant. Any requester holding valid is served within NREQ grants.
- Handshake:
  - A requester may deassert req_valid before it sees ready; that is not an error and nothing is captured.
  - Operand changes after acceptance do not affect the result.
- rsp_ready while rsp_valid=0 is ignored.
- Async reset mid-operation abandons the latched command: no response is issued and rr_ptr returns to 0.

Optional Feature:
- Macro: LOGIC_ARB_STATS_EN.
- Defined: extra output ops_done [15:0], reset 0.
  - Increments on each completed response handshake (rsp_valid & rsp_ready).
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Package logic_unit_pkg:
  - opcode constants OP_NAND=3'd0, OP_NOT=3'd1, OP_AND=3'd2, OP_OR=3'd3, OP_XOR=3'd4.
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Sub-module logic_unit:
  - Purely combinational, parameter WIDTH.
  - Inputs op, a, b; outputs y, err.
  - Instantiated once; reusable by the gate benches.

Test Plan:
- Single op: after reset, requester 0 sends op=2, a=16'hF0F0, b=16'hFF00 → req_ready[0] pulses once; two edges later rsp_valid=1, rsp_id=0, rsp_data=16'hF000, rsp_err=0.
- All ops: requester 1 cycles through ops 0..4 with a=16'hAAAA, b=16'hCCCC → rsp_data = 16'h7777, 16'h5555, 16'h8888, 16'hEEEE, 16'h6666.
- Round-robin: all four valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1; no requester granted twice before the others.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_* stable, no req_ready. rsp_ready=1 → rsp_valid drops the next cycle and the next grant follows.
- Illegal op: op=6, any operands → rsp_data=0, rsp_err=1, rsp_id = the requester.
- Reset mid-op: deassert rst_n while in EXEC → outputs return to reset values immediately. After release with requesters 2 and 3 valid, the first grant is 2. With LOGIC_ARB_STATS_EN defined, ops_done=0.
